// File: rtl/seq_divider.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per clock.
// Define DIVIDER_ROUND_EN to add a round-half-up step on the quotient.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

`ifdef DIVIDER_ROUND_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, ROUND} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic             sub_ok;
    logic [WIDTH-1:0] diff;

    assign accept  = start && (state == IDLE || state == DONE);
    assign shifted = {rem, quo[WIDTH-1]};
    assign sub_ok  = shifted >= {1'b0, dvs};
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    assign diff    = shifted[WIDTH-1:0] - dvs;

    assign Q = quo;
    assign R = rem;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = (D == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
`ifdef DIVIDER_ROUND_EN
                    state_nx = ROUND;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef DIVIDER_ROUND_EN
            ROUND: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (accept) state_nx = (D == '0) ? DONE : RUN;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else if (accept) begin
            dvs <= D;
            cnt <= CW'(WIDTH - 1);
            dbz <= (D == '0);
            if (D == '0) begin
                quo <= '1;
                rem <= X;
            end else begin
                quo <= X;
                rem <= '0;
            end
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            if (sub_ok) begin
                rem <= diff;
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
`ifdef DIVIDER_ROUND_EN
        // Guard bit 2R >= D; cannot overflow since D >= 2 keeps Q below all ones.
        else if (state == ROUND) begin
            quo <= quo + WIDTH'({rem, 1'b0} >= {1'b0, dvs});
        end
`endif
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model checked every
// cycle plus directed vectors with literal expected results.
module tb_seq_divider;
    localparam int W = 4;
`ifdef DIVIDER_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = W + RND;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q, R;
    logic         busy, done, dbz;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(X), .D(D),
        .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;
    int cyc = 0;
    int cur_e = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cur_e);
        end
    endtask

    // Reference model: results from integer arithmetic, timing from accept edge.
    int done_edge = -100;
    int busy_lo = 0;
    int busy_hi = -1;
    int eq = 0, er = 0, edbz = 0;

    function automatic int model_q(input int x, input int d);
        int q;
        q = x / d;
        if (RND != 0 && 2 * (x % d) >= d) q++;
        return q;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            eq = 0; er = 0; edbz = 0;
            done_edge = -100; busy_lo = 0; busy_hi = -1;
        end else if (start && cyc > done_edge) begin
            if (D == 0) begin
                eq = (1 << W) - 1; er = int'(X); edbz = 1;
                done_edge = cyc; busy_lo = 0; busy_hi = -1;
            end else begin
                eq = model_q(int'(X), int'(D)); er = int'(X) % int'(D); edbz = 0;
                done_edge = cyc + LAT; busy_lo = cyc; busy_hi = cyc + LAT - 1;
            end
        end
        cur_e = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (cur_e >= 0) begin
            chk("busy", busy, (cur_e >= busy_lo && cur_e <= busy_hi));
            chk("done", done, (cur_e == done_edge));
            chk("dbz", dbz, edbz);
            if (cur_e >= done_edge) begin
                chk("q_model", Q, eq);
                chk("r_model", R, er);
            end
        end
    end

    // Issue one division from a negedge; returns at the negedge where done is seen.
    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] d,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z, output int lat);
        int n;
        X = x; D = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("timeout", 0, 1);
        q = Q; r = R; z = dbz; lat = n - 1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(name, 0, 1);
    endtask

    logic [W-1:0] q, r;
    logic         z;
    int           lat, t1, t2, qt;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);

        run_div(4'd13, 4'd3, q, r, z, lat);
        chk("t13_3_q", q, 4); chk("t13_3_r", r, 1); chk("t13_3_dbz", z, 0);
        chk("t13_3_lat", lat, LAT);

        run_div(4'd15, 4'd2, q, r, z, lat);
        chk("t15_2_q", q, RND != 0 ? 8 : 7); chk("t15_2_r", r, 1);

        run_div(4'd14, 4'd4, q, r, z, lat);
        chk("t14_4_q", q, RND != 0 ? 4 : 3); chk("t14_4_r", r, 2);

        run_div(4'd9, 4'd0, q, r, z, lat);
        chk("dbz_q", q, 15); chk("dbz_r", r, 9); chk("dbz_flag", z, 1);
        chk("dbz_lat", lat, 0);

        // back-to-back with start held high through DONE
        X = 4'd13; D = 4'd3; start = 1'b1;
        @(negedge clk);
        X = 4'd6; D = 4'd6;
        wait_done("b2b_timeout1");
        t1 = cur_e;
        chk("b2b_q1", Q, 4); chk("b2b_r1", R, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_timeout2");
        t2 = cur_e;
        chk("b2b_gap", t2 - t1, LAT + 1);
        chk("b2b_q2", Q, 1); chk("b2b_r2", R, 0);

        // start pulsed mid-RUN must be ignored
        X = 4'd13; D = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        X = 4'd9; D = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mid_timeout");
        chk("mid_q", Q, 4); chk("mid_r", R, 1); chk("mid_dbz", dbz, 0);
        @(negedge clk);

        // reset during the third RUN cycle
        X = 4'd13; D = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_q", Q, 0); chk("mrst_r", R, 0);
        chk("mrst_busy", busy, 0); chk("mrst_done", done, 0); chk("mrst_dbz", dbz, 0);
        @(negedge clk);
        run_div(4'd13, 4'd3, q, r, z, lat);
        chk("post_rst_q", q, 4); chk("post_rst_r", r, 1); chk("post_rst_lat", lat, LAT);

        for (int x = 0; x < 16; x++) begin
            for (int d = 1; d < 16; d++) begin
                run_div(W'(x), W'(d), q, r, z, lat);
                qt = int'(q);
                if (RND != 0 && 2 * int'(r) >= d) qt = qt - 1;
                chk("sweep_identity", qt * d + int'(r), x);
                chk("sweep_r_lt_d", (int'(r) < d), 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned integer divider for the arithmetic datapath. It is the inverse operation of the array multipliers: it accepts a WIDTH-bit dividend and divisor and produces quotient and remainder with a restoring radix-2 algorithm. One quotient bit is resolved per clock. A start/done handshake lets a controller issue back-to-back divisions.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a division; sampled at a rising edge.
- X  input  WIDTH  unsigned dividend; sampled with start.
- D  input  WIDTH  unsigned divisor; sampled with start.
- Q  output  WIDTH  quotient.
- R  output  WIDTH  remainder.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse; Q, R and dbz are valid.
- dbz  output  1  divide-by-zero flag for the current result.

## Operation
- FSM states: IDLE, RUN, DONE (plus ROUND when DIVIDER_ROUND_EN is defined).
- Reset with rst_n=0 at an edge:
  - state goes to IDLE.
  - Q, R, busy, done and dbz all go to 0.
  - The iteration counter goes to 0.
  - Reset takes priority over everything, including a division in progress. The partial result is discarded.
- start is accepted only in IDLE or DONE. In RUN or ROUND it is ignored, with no queuing.
- On accept:
  - Latch X into the quotient/dividend shift register and D into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and set the counter to WIDTH-1.
  - If D=0: go to DONE directly with Q = all ones, R = X, dbz=1.
  - Otherwise go to RUN with dbz=0.
- RUN iteration, one per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = partial remainder − D.
  - If trial ≥ 0: partial remainder ← trial and shift in quotient bit 1. Otherwise keep the remainder and shift in quotient bit 0.
  - Decrement the counter. The last iteration is the one taken when the counter equals 0.
- After the last iteration, go to DONE (or to ROUND when rounding is enabled).
- In DONE, done=1. Q and R hold their values until the next accepted start or reset.
- From DONE:
  - With start=1: accept the new division. done drops next cycle.
  - With start=0: go to IDLE.
- Results satisfy X = Q·D + R with R < D. Q and R hold their last values in IDLE.

## Timing
- Let start be accepted at edge k with D≠0.
- busy=1 during the cycles after edges k through k+WIDTH−1 (WIDTH cycles). It is low in IDLE and DONE.
- done=1 for exactly the cycle after edge k+WIDTH (rounding disabled) or k+WIDTH+1 (rounding enabled).
- Divide by zero: done=1 in the cycle after edge k, and busy never rises.
- Back-to-back: start held high in DONE gives a new result every WIDTH+1 cycles (WIDTH+2 with rounding).
- X and D may change freely after the accept edge.

## Configuration
- DIVIDER_ROUND_EN defined:
  - Adds the ROUND state, one cycle after the last RUN iteration.
  - Guard bit = (2·R ≥ D). Q ← Q + guard, which is round-half-up.
  - The sum cannot overflow: D=1 gives guard=0, and D≥2 bounds Q below all ones.
  - R remains the truncated-division remainder.
  - busy stays high during ROUND.
  - Divide-by-zero skips ROUND.
- DIVIDER_ROUND_EN undefined:
  - No ROUND state.
  - Q is the truncated quotient and latency is WIDTH cycles to done.

## Test plan
- WIDTH=4, X=13, D=3, start at edge 0 → busy for 4 cycles, done in the cycle after edge 4, Q=4, R=1, dbz=0. With rounding: done after edge 5, Q=4.
- X=15, D=2 → Q=7, R=1. With DIVIDER_ROUND_EN: Q=8, R=1. Also check X=14, D=4 → rounded Q=4.
- X=9, D=0 → done in the cycle after edge 0, Q=15, R=9, dbz=1, busy never high.
- Start held high across DONE with operand pairs (13,3) then (6,6) → second done exactly WIDTH+1 cycles after the first, Q=1, R=0. Also pulse start mid-RUN → ignored, first result unchanged.
- Assert rst_n=0 for one edge during the third RUN cycle → next cycle Q=R=0 and busy=done=dbz=0, state IDLE. A new start 13/3 then completes normally.
- Exhaustive WIDTH=4 sweep over all X and all D≠0 → Q·D+R=X and R<D on every done pulse, with exactly one done per accepted start.
